// File: rtl/muldiv_unit_if.sv
// Core-side bundle for the iterative multiply/divide unit: operands in, regfile write out.
interface muldiv_unit_if #(parameter int unsigned XLEN = 32);
   logic            i_start;
   logic [2:0]      i_funct3;
   logic [XLEN-1:0] i_rs1_data;
   logic [XLEN-1:0] i_rs2_data;
   logic [4:0]      i_rd_addr;
   logic            o_stall;
   logic            o_busy;
   logic [4:0]      o_rd_addr;
   logic [XLEN-1:0] o_rd_data;
   logic            o_rd_wren;

   modport master (
      output i_start, i_funct3, i_rs1_data, i_rs2_data, i_rd_addr,
      input  o_stall, o_busy, o_rd_addr, o_rd_data, o_rd_wren
   );

   modport slave (
      input  i_start, i_funct3, i_rs1_data, i_rs2_data, i_rd_addr,
      output o_stall, o_busy, o_rd_addr, o_rd_data, o_rd_wren
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: XLEN-step shift-add multiply / restoring divide on operand magnitudes,
// followed by a sign-fix cycle and a single-cycle regfile write strobe.
module muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic        i_clk,
   input  logic        i_reset,
   muldiv_unit_if.slave bus
);
   localparam int unsigned CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [2:0]        f3_q, f3_d;
   logic [4:0]        rd_q, rd_d;
   logic              neg_a_q, neg_a_d;
   logic              neg_b_q, neg_b_d;
   logic [XLEN-1:0]   res_q, res_d;
   logic [4:0]        rd_out_q, rd_out_d;

   logic              signed_a, signed_b, in_neg_a, in_neg_b;
   logic [XLEN-1:0]   abs_a, abs_b;
   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic              div_ok;
   logic [2*XLEN-1:0] mul_next, div_next, prod;
   logic [XLEN-1:0]   quo, rem;

   // Operand conditioning at accept: magnitudes plus sign flags by funct3.
   always_comb begin
      signed_a = bus.i_funct3[2] ? ~bus.i_funct3[0] : (bus.i_funct3 != 3'b011);
      signed_b = bus.i_funct3[2] ? ~bus.i_funct3[0] : ~bus.i_funct3[1];
      in_neg_a = signed_a & bus.i_rs1_data[XLEN-1];
      in_neg_b = signed_b & bus.i_rs2_data[XLEN-1];
      abs_a    = in_neg_a ? -bus.i_rs1_data : bus.i_rs1_data;
      abs_b    = in_neg_b ? -bus.i_rs2_data : bus.i_rs2_data;
   end

   // One radix-2 step; acc holds {partial/remainder, multiplier/quotient}.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : (XLEN+1)'(0));
      mul_next  = {mul_sum, acc_q[XLEN-1:1]};
      div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, b_q};
      div_ok    = ~div_diff[XLEN];
      div_next  = {(div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ok};
   end

   // Sign correction; a zero divisor leaves rem = |rs1| so only the quotient needs overriding.
   always_comb begin
      prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
      rem  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      if (b_q == '0) quo = '1;
      else           quo = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      b_d      = b_q;
      f3_d     = f3_q;
      rd_d     = rd_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      res_d    = res_q;
      rd_out_d = rd_out_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.i_start) begin
               acc_d   = {(XLEN)'(0), abs_a};
               b_d     = abs_b;
               f3_d    = bus.i_funct3;
               rd_d    = bus.i_rd_addr;
               neg_a_d = in_neg_a;
               neg_b_d = in_neg_b;
               cnt_d   = '0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            acc_d = f3_q[2] ? div_next : mul_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
         end
         S_FIX: begin
            unique case (f3_q)
               3'b000:                 res_d = prod[XLEN-1:0];
               3'b001, 3'b010, 3'b011: res_d = prod[2*XLEN-1:XLEN];
               3'b100, 3'b101:         res_d = quo;
               default:                res_d = rem;
            endcase
            rd_out_d = rd_q;
            state_d  = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         b_q      <= '0;
         f3_q     <= '0;
         rd_q     <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         res_q    <= '0;
         rd_out_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         b_q      <= b_d;
         f3_q     <= f3_d;
         rd_q     <= rd_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         res_q    <= res_d;
         rd_out_q <= rd_out_d;
      end
   end

   // Stall is combinational so the core freezes in the very cycle the op is decoded.
   assign bus.o_stall   = i_reset & (((state_q == S_IDLE) & bus.i_start) |
                                     (state_q == S_CALC) | (state_q == S_FIX));
   assign bus.o_busy    = (state_q != S_IDLE);
   assign bus.o_rd_wren = (state_q == S_DONE);
   assign bus.o_rd_data = res_q;
   assign bus.o_rd_addr = rd_out_q;
endmodule
